// File: rtl/bus_xfer_pkg.sv
// Shared types and widths for the bus transfer sequencer and its decoders.
package bus_xfer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      WAIT  = 2'd2,
      LATCH = 2'd3
   } xfer_state_e;

   localparam int DEF_NUM_UNITS = 8;
   localparam int DEF_ID_W      = 3;
   localparam int SETTLE_W      = 4;
   localparam int TIMEOUT_W     = 8;

   // A request is only usable when it names two different agents that both exist.
   function automatic logic ids_legal(input int src, input int dst, input int numUnits);
      return (src != dst) && (src < numUnits) && (dst < numUnits);
   endfunction

endpackage

// File: rtl/id_onehot_dec.sv
// Gated ID to one-hot decoder; IDs with no matching agent decode to all-zero.
module id_onehot_dec #(
   parameter int ID_W      = 3,
   parameter int NUM_UNITS = 8
)(
   input  logic [ID_W-1:0]      i_id,
   input  logic                 i_gate,
   output logic [NUM_UNITS-1:0] o_onehot
);

   always_comb begin
      o_onehot = '0;
      for (int k = 0; k < NUM_UNITS; k++) begin
         if (i_gate && (i_id == ID_W'(k))) begin
            o_onehot[k] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bus_transfer_ctrl.sv
// Initiator for the enable/latch bus protocol: drives one source onto the shared
// DATA bus, optionally waits for a slow source, then strobes one destination.
module bus_transfer_ctrl
   import bus_xfer_pkg::*;
#(
   parameter int NUM_UNITS     = DEF_NUM_UNITS,
   parameter int ID_W          = DEF_ID_W,
   parameter int SETTLE_CYCLES = 1,
   parameter int WAIT_TIMEOUT  = 15
)(
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [ID_W-1:0]      req_src,
   input  logic [ID_W-1:0]      req_dst,
   input  logic                 req_wait,
   input  logic                 src_ack,
   output logic [NUM_UNITS-1:0] enable,
   output logic [NUM_UNITS-1:0] latch,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);

   localparam logic [SETTLE_W-1:0]  SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);
   localparam logic [TIMEOUT_W-1:0] TMO_LAST    = TIMEOUT_W'(WAIT_TIMEOUT - 1);

   xfer_state_e          r_state;
   logic                 r_ready;
   logic                 r_done;
   logic                 r_err;
   logic [ID_W-1:0]      r_src;
   logic [ID_W-1:0]      r_dst;
   logic                 r_wait;
   logic [SETTLE_W-1:0]  r_settle;
   logic [TIMEOUT_W-1:0] r_tmo;

   logic                 w_reqLegal;
   logic                 w_enGate;
   logic                 w_latGate;

   assign w_reqLegal = ids_legal(int'(req_src), int'(req_dst), NUM_UNITS);

   // r_ready resets low even though the state is IDLE, so nothing is accepted
   // until the first edge after reset release.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= IDLE;
         r_ready  <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
         r_src    <= '0;
         r_dst    <= '0;
         r_wait   <= 1'b0;
         r_settle <= '0;
         r_tmo    <= '0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (r_ready && req_valid) begin
                  if (w_reqLegal) begin
                     r_src    <= req_src;
                     r_dst    <= req_dst;
                     r_wait   <= req_wait;
                     r_settle <= SETTLE_LOAD;
                     r_ready  <= 1'b0;
                     r_state  <= DRIVE;
                  end else begin
                     r_err <= 1'b1;
                  end
               end else begin
                  r_ready <= 1'b1;
               end
            end
            DRIVE: begin
               if (r_settle == '0) begin
                  r_tmo   <= '0;
                  r_state <= r_wait ? WAIT : LATCH;
               end else begin
                  r_settle <= r_settle - 1'b1;
               end
            end
            WAIT: begin
               if (src_ack) begin
                  r_state <= LATCH;
               end else if (r_tmo == TMO_LAST) begin
                  r_err   <= 1'b1;
                  r_ready <= 1'b1;
                  r_state <= IDLE;
               end else begin
                  r_tmo <= r_tmo + 1'b1;
               end
            end
            LATCH: begin
               r_done  <= 1'b1;
               r_ready <= 1'b1;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Strobes decode only registered state, so reset clears them without a clock.
   assign w_enGate  = (r_state != IDLE);
   assign w_latGate = (r_state == LATCH);

   id_onehot_dec #(.ID_W(ID_W), .NUM_UNITS(NUM_UNITS)) u_enableDec (
      .i_id     (r_src),
      .i_gate   (w_enGate),
      .o_onehot (enable)
   );

   id_onehot_dec #(.ID_W(ID_W), .NUM_UNITS(NUM_UNITS)) u_latchDec (
      .i_id     (r_dst),
      .i_gate   (w_latGate),
      .o_onehot (latch)
   );

   assign req_ready = r_ready;
   assign busy      = w_enGate;
   assign done      = r_done;
   assign err       = r_err;

endmodule

// File: doc/bus_transfer_ctrl.md
# bus_transfer_ctrl

Sequencer that owns the shared 16-bit tristate DATA bus and issues the `enable`/`latch` strobes to the bus-attached registers (PSW, general registers, memory data register). It accepts one transfer request at a time, `(src, dst, wait)`, drives exactly one source onto the bus, and strobes exactly one destination to capture it. It is the initiator side of the enable/latch register protocol and sits between instruction sequencing and the register file.

## Interface
- `NUM_UNITS`, 8: number of bus agents; one enable line and one latch line each.
- `ID_W`, 3: width of agent IDs; `2**ID_W >= NUM_UNITS`.
- `SETTLE_CYCLES`, 1: cycles the source is enabled before the latch strobe; range 1..15.
- `WAIT_TIMEOUT`, 15: maximum cycles in WAIT before abort; range 1..255.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: a transfer request is present.
- `req_ready` out 1: the controller can accept a request.
- `req_src` in ID_W: ID of the source agent to enable.
- `req_dst` in ID_W: ID of the destination agent to latch.
- `req_wait` in 1: the source is slow; hold the source enable until `src_ack`.
- `src_ack` in 1: a slow source reports that its data is valid on the bus.
- `enable` out NUM_UNITS: one-hot source drive strobes.
- `latch` out NUM_UNITS: one-hot destination capture strobes.
- `busy` out 1: a transfer is in progress (state is not IDLE).
- `done` out 1: one-cycle pulse when a transfer has completed.
- `err` out 1: one-cycle pulse on a rejected request or a timeout.

## Operation
- States are IDLE, DRIVE, WAIT and LATCH.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`, the controller registers src, dst and wait.
  - If src==dst, or either ID is >= NUM_UNITS, the request is rejected: `err` pulses next cycle, state stays IDLE, and no strobe is asserted.
  - Otherwise the next state is DRIVE and the settle counter loads SETTLE_CYCLES-1.
- **DRIVE**
  - `enable[src]`=1.
  - The settle counter decrements each cycle.
  - At 0: go to WAIT if `wait`=1, else go to LATCH.
- **WAIT**
  - `enable[src]`=1.
  - The timeout counter starts at 0 and increments each cycle.
  - When `src_ack`=1 is sampled, go to LATCH.
  - When the counter reaches WAIT_TIMEOUT-1 with no ack, go to IDLE: `err` pulses, no `latch` is asserted, and `done` is not pulsed.
  - `src_ack` is ignored outside WAIT.
- **LATCH**
  - `enable[src]`=1 and `latch[dst]`=1 for exactly one cycle; the destination captures at the closing edge.
  - Then go to IDLE with `done` pulsing.
- **Invariants**
  - At most one `enable` bit and at most one `latch` bit are high in any cycle.
  - `latch` is never high without `enable` of a different agent.
  - `enable` and `latch` are all-zero in IDLE.
- All strobes are decoded from registered state and registered IDs, so there are no combinational paths from `req_*` to `enable`/`latch`.
- Back-to-back transfers: a request can be accepted in the same cycle `done` or `err` is high.

## Timing
- **Reset values:** all outputs are 0 while `reset_n`=0. This includes `req_ready`, `enable`, `latch`, `busy`, `done` and `err`.
  - `req_ready` becomes 1 on the first edge after `reset_n` deasserts.
- **Reset mid-transfer:** `enable` and `latch` clear asynchronously, immediately; the bus must float. The transfer is lost with no `done` and no `err`.
- **Latency, no wait, SETTLE_CYCLES=1** (accept edge at cycle t):
  - DRIVE in cycle t+1.
  - LATCH in cycle t+2.
  - `done` and `req_ready` in cycle t+3.
  - Total bus occupancy is 2 cycles.
- **General latency:** accept-to-done is SETTLE_CYCLES + W + 2 cycles, where W is the number of WAIT cycles.
  - `src_ack` sampled in the first WAIT cycle gives W=1.
- **Rejection:** `err` pulses in cycle t+1 and `req_ready` stays 1.
- **Timeout:** `err` pulses and `enable` drops in the same cycle, WAIT_TIMEOUT cycles after WAIT is entered.

## Structure
- Package `bus_xfer_pkg` holds:
  - the state enum (IDLE, DRIVE, WAIT, LATCH);
  - the default widths;
  - the SETTLE/TIMEOUT counter widths (4 and 8 bits).
- Sub-module `id_onehot_dec`: parameterised ID_W to NUM_UNITS one-hot decoder with a gate input. It is instantiated twice, once for `enable` and once for `latch`.

## Test plan
- **Basic transfer:** reset, then src=3, dst=5, wait=0. Required: `enable`=8'h08 for cycles t+1..t+2, `latch`=8'h20 only in t+2, `done` in t+3, and the dst register holds the bus value.
- **Slow source:** src=1, dst=2, wait=1, `src_ack` raised 4 cycles after WAIT entry. Required: `enable`=8'h02 through WAIT, a single `latch`=8'h04 cycle, then `done`.
- **Timeout:** wait=1, `src_ack` held 0, WAIT_TIMEOUT=15. Required: `err` pulse and `enable`=0 after 15 WAIT cycles, no `latch`, no `done`.
- **Illegal request:** src=dst=4. Required: `err` pulse at t+1, `enable`/`latch` stay 0, `req_ready` stays 1.
- **Reset mid-transfer:** pull `reset_n` low during LATCH. Required: `enable`/`latch` drop to 0 with no clock edge, and the next request after release completes normally.
- **Back-to-back:** `req_valid` held with two requests queued by the bench. Required: the second request is accepted in the `done` cycle, and the one-hot invariants hold on every cycle (checked by assertion).
